decode_cycle: RTL and testbench

- Second stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs (InstrD, PCD, PCPlus4D).
- Decodes control signals, reads the 32x32 register file, and sign-extends the immediate.
- Registers everything into the ID/EX pipeline register feeding the execute stage.
- Also hosts the writeback port of the register file, driven from the writeback stage.

---
 rtl/riscv_pkg.sv | 47 ++++
 rtl/control_unit.sv | 91 +++++++++
 rtl/reg_file.sv | 50 +++++
 rtl/sign_extend.sv | 31 +++
 rtl/decode_cycle.sv | 144 ++++++++++++++
 tb/tb_decode_cycle.sv | 228 ++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I decode definitions used by the decode stage and its helpers:
//   - architectural sizes (datapath width, register count)
//   - major opcode constants
//   - immediate-format selector enum
//   - ALUControl, ResultSrc and ALUOp encodings
// No ports (package only).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int RV_XLEN  = 32;
    localparam int RV_NREGS = 32;

    // Major opcodes handled by the main decoder
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // ALUControl encodings consumed by the execute stage
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ResultSrc encodings consumed by the writeback mux
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Main decoder -> ALU decoder handshake
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Combinational main decoder plus ALU decoder for the RV32I subset
// lw, sw, R-type, I-ALU, beq, jal. Unknown opcodes decode to all-zero
// controls so they behave as a nop downstream.
// Ports:
//   op, funct3, funct7b5   instruction fields
//   reg_write ... imm_src  decoded control signals
// ---------------------------------------------------------------------------
module control_unit
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       mem_write,
    output logic       jump,
    output logic       branch,
    output logic [2:0] alu_control,
    output logic       alu_src,
    output imm_src_t   imm_src
);

    logic [1:0] w_alu_op;

    always_comb begin
        reg_write  = 1'b0;
        result_src = RES_ALU;
        mem_write  = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_src    = 1'b0;
        imm_src    = IMM_I;
        w_alu_op   = ALUOP_ADD;
        case (op)
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
            end
            OP_SW: begin
                mem_write = 1'b1;
                imm_src   = IMM_S;
                alu_src   = 1'b1;
            end
            OP_RTYPE: begin
                reg_write = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                imm_src  = IMM_B;
                w_alu_op = ALUOP_SUB;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                imm_src    = IMM_J;
                result_src = RES_PC4;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = ALU_ADD;
        case (w_alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // op[5] separates R-type from I-ALU: addi with imm[10]=1
                    // must stay an add, only the R-type sub uses funct7[5].
                    3'b000:  alu_control = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Architectural register file: one synchronous write port, two combinational
// read ports with same-cycle write-to-read bypass. x0 always reads as zero.
// All entries clear asynchronously while rst is low.
// Ports:
//   clk, rst      clock, async active-low reset
//   we, wa, wd    write enable / address / data (writeback stage)
//   ra1, ra2      read addresses
//   rd1, rd2      read data
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_valid;

    // A write to x0 is never a real write, for storage and bypass alike.
    assign w_wr_valid = we && (wa != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wa] <= wd;
        end
    end

    // Bypass lets the decode stage see a result that the writeback stage is
    // committing in this very cycle, closing the WB->ID hazard window.
    assign rd1 = (ra1 == 5'd0)                 ? '0 :
                 (w_wr_valid && (wa == ra1))   ? wd : r_regs[ra1];
    assign rd2 = (ra2 == 5'd0)                 ? '0 :
                 (w_wr_valid && (wa == ra2))   ? wd : r_regs[ra2];

endmodule

// File: rtl/sign_extend.sv
// ---------------------------------------------------------------------------
// sign_extend
// Assembles the I/S/B/J immediate from the instruction and sign-extends it
// from instr[31].
// Ports:
//   instr    instruction bits [31:7] (opcode not needed)
//   imm_src  immediate format selector
//   imm_ext  32-bit extended immediate
// ---------------------------------------------------------------------------
module sign_extend
    import riscv_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_src_t    imm_src,
    output logic [31:0] imm_ext
);

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/decode_cycle.sv
// ---------------------------------------------------------------------------
// decode_cycle
// ID stage of the 5-stage RV32I pipeline: decodes controls, reads the
// register file (whose write port is driven by writeback), extends the
// immediate and registers everything into the ID/EX pipeline register.
// Ports:
//   clk, rst                    clock, async active-low reset
//   FlushE                      bubble insert into ID/EX
//   InstrD, PCD, PCPlus4D       from IF/ID
//   RegWriteW, RdW, ResultW     writeback port of the register file
//   Rs1D, Rs2D                  combinational source fields for hazard unit
//   *E                          ID/EX register outputs to execute
// ---------------------------------------------------------------------------
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = RV_NREGS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            FlushE,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [31:0]     ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);

    logic            w_reg_write, w_mem_write, w_jump, w_branch, w_alu_src;
    logic [1:0]      w_result_src;
    logic [2:0]      w_alu_control;
    imm_src_t        w_imm_src;
    logic [XLEN-1:0] w_rd1, w_rd2;
    logic [31:0]     w_imm_ext;

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    control_unit u_ctrl (
        .op          (InstrD[6:0]),
        .funct3      (InstrD[14:12]),
        .funct7b5    (InstrD[30]),
        .reg_write   (w_reg_write),
        .result_src  (w_result_src),
        .mem_write   (w_mem_write),
        .jump        (w_jump),
        .branch      (w_branch),
        .alu_control (w_alu_control),
        .alu_src     (w_alu_src),
        .imm_src     (w_imm_src)
    );

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RdW),
        .wd  (ResultW),
        .ra1 (Rs1D),
        .ra2 (Rs2D),
        .rd1 (w_rd1),
        .rd2 (w_rd2)
    );

    sign_extend u_sext (
        .instr   (InstrD[31:7]),
        .imm_src (w_imm_src),
        .imm_ext (w_imm_ext)
    );

    // ID/EX register. A flush loads all zeros, which is a nop: no writes,
    // no memory store, no control transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUControlE <= '0;
            ALUSrcE     <= 1'b0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= w_reg_write;
            ResultSrcE  <= w_result_src;
            MemWriteE   <= w_mem_write;
            JumpE       <= w_jump;
            BranchE     <= w_branch;
            ALUControlE <= w_alu_control;
            ALUSrcE     <= w_alu_src;
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ImmExtE     <= w_imm_ext;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= InstrD[11:7];
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// ---------------------------------------------------------------------------
// tb_decode_cycle
// Directed bench for decode_cycle. Each step drives one instruction plus an
// optional writeback, pushes the expected ID/EX contents onto a scoreboard
// queue and pops/compares it half a cycle after the capturing edge.
// ---------------------------------------------------------------------------
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        FlushE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    decode_cycle dut (
        .clk(clk), .rst(rst), .FlushE(FlushE),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic        jmp;
        logic        br;
        logic [2:0]  aluc;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic        imm_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic [31:0] pc_q;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk(tag, "RegWriteE",   {31'd0, RegWriteE},  {31'd0, e.rw});
        chk(tag, "ResultSrcE",  {30'd0, ResultSrcE}, {30'd0, e.rsrc});
        chk(tag, "MemWriteE",   {31'd0, MemWriteE},  {31'd0, e.mw});
        chk(tag, "JumpE",       {31'd0, JumpE},      {31'd0, e.jmp});
        chk(tag, "BranchE",     {31'd0, BranchE},    {31'd0, e.br});
        chk(tag, "ALUControlE", {29'd0, ALUControlE},{29'd0, e.aluc});
        chk(tag, "ALUSrcE",     {31'd0, ALUSrcE},    {31'd0, e.alusrc});
        chk(tag, "RD1E", RD1E, e.rd1);
        chk(tag, "RD2E", RD2E, e.rd2);
        if (e.imm_valid) chk(tag, "ImmExtE", ImmExtE, e.imm);
        chk(tag, "Rs1E", {27'd0, Rs1E}, {27'd0, e.rs1});
        chk(tag, "Rs2E", {27'd0, Rs2E}, {27'd0, e.rs2});
        chk(tag, "RdE",  {27'd0, RdE},  {27'd0, e.rd});
        chk(tag, "PCE", PCE, e.pc);
        chk(tag, "PCPlus4E", PCPlus4E, e.pc4);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0)                  return 32'd0;
        if (we && wa != 5'd0 && wa == ra) return wd;
        return mregs[ra];
    endfunction

    // Reference decoder written straight from the instruction-set tables.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [1:0] aluop;
        logic [2:0] f3;
        e     = '0;
        aluop = 2'b00;
        f3    = ins[14:12];
        case (ins[6:0])
            7'b0000011: begin e.rw = 1; e.alusrc = 1; e.rsrc = 2'b01; e.imm_valid = 1;
                              e.imm = {{20{ins[31]}}, ins[31:20]}; end
            7'b0100011: begin e.mw = 1; e.alusrc = 1; e.imm_valid = 1;
                              e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
            7'b0110011: begin e.rw = 1; aluop = 2'b10; end
            7'b1100011: begin e.br = 1; aluop = 2'b01; e.imm_valid = 1;
                              e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'b0010011: begin e.rw = 1; e.alusrc = 1; aluop = 2'b10; e.imm_valid = 1;
                              e.imm = {{20{ins[31]}}, ins[31:20]}; end
            7'b1101111: begin e.rw = 1; e.jmp = 1; e.rsrc = 2'b10; e.imm_valid = 1;
                              e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            default: ;
        endcase
        if (aluop == 2'b01)      e.aluc = 3'b001;
        else if (aluop == 2'b10) begin
            if (f3 == 3'b000)      e.aluc = (ins[30] && ins[5]) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) e.aluc = 3'b101;
            else if (f3 == 3'b110) e.aluc = 3'b011;
            else if (f3 == 3'b111) e.aluc = 3'b010;
            else                   e.aluc = 3'b000;
        end
        e.rd1 = r1;  e.rd2 = r2;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.pc  = pc;  e.pc4 = pc + 32'd4;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = '0;
        e.imm_valid = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input string tag, input logic [31:0] ins, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] r1, r2;
        InstrD = ins; PCD = pc_q; PCPlus4D = pc_q + 32'd4; FlushE = fl;
        RegWriteW = we; RdW = wa; ResultW = wd;
        #1;
        chk(tag, "Rs1D", {27'd0, Rs1D}, {27'd0, ins[19:15]});
        chk(tag, "Rs2D", {27'd0, Rs2D}, {27'd0, ins[24:20]});
        r1 = model_read(ins[19:15], we, wa, wd);
        r2 = model_read(ins[24:20], we, wa, wd);
        e  = fl ? zero_exp() : model(ins, pc_q, r1, r2);
        sb.push_back(e);
        @(posedge clk);
        if (we && wa != 5'd0) mregs[wa] = wd;
        @(negedge clk);
        cmp_all(tag, sb.pop_front());
        $display("step %-10s instr=%h flush=%0d wb=%0d x%0d<=%h", tag, ins, fl, we, wa, wd);
        pc_q = pc_q + 32'd4;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        pc_q = 32'h0000_1000;
        rst = 1'b0; FlushE = 1'b0; InstrD = 32'h0050_0093;
        PCD = pc_q; PCPlus4D = pc_q + 32'd4;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;

        // Reset held across several edges: everything stays zero.
        repeat (3) @(negedge clk);
        cmp_all("reset_hold", zero_exp());
        rst = 1'b1;

        step("addi",       32'h0050_0093,              0, 0, 5'd0, 32'h0);
        step("add_bypass", 32'h0020_81B3,              0, 1, 5'd2, 32'hDEAD_BEEF);
        chk("add_bypass", "RD2E_const", RD2E, 32'hDEAD_BEEF);
        step("wb_x1",      enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 0, 1, 5'd1, 32'h1111_1111);
        step("x0_write",   enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd4), 0, 1, 5'd0, 32'h0000_1234);
        step("x0_read",    enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd5), 0, 0, 5'd0, 32'h0);
        step("sub",        enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd8), 0, 0, 5'd0, 32'h0);
        step("slt",        enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd9), 0, 0, 5'd0, 32'h0);
        step("or",         enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd9), 0, 0, 5'd0, 32'h0);
        step("and",        enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd9), 0, 0, 5'd0, 32'h0);
        step("addi_b30",   enc_i(12'h400, 5'd1, 3'b000, 5'd10), 0, 0, 5'd0, 32'h0);
        step("andi_neg",   enc_i(12'hF0F, 5'd2, 3'b111, 5'd11), 0, 0, 5'd0, 32'h0);
        step("beq",        32'hFE00_0EE3,              0, 0, 5'd0, 32'h0);
        chk("beq", "ImmExtE_const", ImmExtE, 32'hFFFF_FFFC);
        step("jal",        32'h0080_006F,              0, 0, 5'd0, 32'h0);
        chk("jal", "ImmExtE_const", ImmExtE, 32'h0000_0008);
        step("lw",         32'h0040_2283,              0, 0, 5'd0, 32'h0);
        step("lw_flush",   32'h0040_2283,              1, 1, 5'd6, 32'hCAFE_F00D);
        step("x6_read",    enc_r(7'h00, 5'd0, 5'd6, 3'b000, 5'd7), 0, 0, 5'd0, 32'h0);
        step("illegal",    32'h0000_0000,              0, 0, 5'd0, 32'h0);
        step("sw",         {7'h00, 5'd6, 5'd1, 3'b010, 5'd8, 7'b0100011}, 0, 0, 5'd0, 32'h0);

        // Asynchronous reset between edges: outputs clear with no clock edge.
        #2;
        rst = 1'b0;
        #1;
        cmp_all("async_rst", zero_exp());
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(negedge clk);
        rst = 1'b1;
        pc_q = 32'h0000_2000;
        step("post_rst",   enc_r(7'h00, 5'd2, 5'd6, 3'b000, 5'd7), 0, 0, 5'd0, 32'h0);
        step("post_rst_x1",enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd7), 0, 0, 5'd0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
